// File: rtl/lbuf_pkg.sv
// Shared types and defaults for the ping-pong line buffer controller.
`timescale 1ns/1ps
package lbuf_pkg;

  localparam int LBUF_DATA_W   = 10;
  localparam int LBUF_MAX_HACT = 2048;

  // Address width for a buffer holding the given number of pixels (at least 1 bit)
  function automatic int lbuf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int LBUF_ADDR_W = lbuf_addr_w(LBUF_MAX_HACT);

  typedef struct packed {
    logic [LBUF_DATA_W-1:0] r;
    logic [LBUF_DATA_W-1:0] g;
    logic [LBUF_DATA_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    BUF_A = 1'b0,
    BUF_B = 1'b1
  } buf_sel_e;

endpackage

// File: rtl/lbuf_ram.sv
// Single-port line RAM: one address per cycle, optional write, registered read.
// Contents are never reset; the controller only trusts locations it wrote.
`timescale 1ns/1ps
module lbuf_ram
  import lbuf_pkg::*;
#(
  parameter int WIDTH  = 3 * LBUF_DATA_W,
  parameter int DEPTH  = LBUF_MAX_HACT,
  parameter int ADDR_W = lbuf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write when enabled and always return the old word at the address one cycle later
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/line_buf_ctrl_top.sv
// Ping-pong line buffer: outputs the previous line's pixel at the same x,
// with syncs and data delayed by two clocks.
// Optional macro LBUF_FIRST_LINE_ZERO_EN: first line of a frame outputs zero
// data instead of passing the current pixel through.
`timescale 1ns/1ps
module line_buf_ctrl_top
  import lbuf_pkg::*;
#(
  parameter int DATA_W    = LBUF_DATA_W,
  parameter int MAX_HACT  = LBUF_MAX_HACT,
  parameter int VSYNC_POL = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_r_data,
  input  logic [DATA_W-1:0] i_g_data,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [DATA_W-1:0] o_r_data,
  output logic [DATA_W-1:0] o_g_data,
  output logic [DATA_W-1:0] o_b_data
);

  localparam int   ADDR_W = lbuf_addr_w(MAX_HACT);
  localparam int   X_W    = ADDR_W + 1;
  localparam int   PIX_W  = 3 * DATA_W;
  localparam logic VS_POL = (VSYNC_POL != 0);

  logic             vs_act;
  logic             frame_start;
  logic             de_fall;
  logic             in_range;
  logic             wr_en;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0] wr_pix;
  logic [PIX_W-1:0] rdata_a;
  logic [PIX_W-1:0] rdata_b;
  logic [PIX_W-1:0] rd_pix;

  buf_sel_e         sel_q, sel_d, sel_eff;
  logic [X_W-1:0]   x_q, x_d, x_eff;
  logic             first_q, first_d, first_eff;
  logic             de_prev_q;
  logic             vs_act_q;

  logic             vs_p1_q, hs_p1_q, de_p1_q;
  logic             valid_p1_q, first_p1_q;
  buf_sel_e         rd_sel_p1_q;
  logic [PIX_W-1:0] pix_p1_q;

  logic             vs_out_q, hs_out_q, de_out_q;
  logic [PIX_W-1:0] data_q, data_d;

  assign vs_act      = i_vsync ^ VS_POL;
  assign frame_start = vs_act & ~vs_act_q;
  assign de_fall     = de_prev_q & ~i_de;
  assign wr_pix      = {i_r_data, i_g_data, i_b_data};

  // Line/frame control: frame start overrides held state, then a de falling edge swaps buffers
  always_comb begin
    sel_eff   = frame_start ? BUF_A : sel_q;
    x_eff     = frame_start ? '0 : x_q;
    first_eff = frame_start | first_q;
    in_range  = (x_eff < X_W'(MAX_HACT));
    wr_en     = i_de & in_range & rstn;
    addr      = x_eff[ADDR_W-1:0];
    sel_d     = sel_eff;
    first_d   = first_eff;
    x_d       = '0;
    if (de_fall) begin
      sel_d   = (sel_eff == BUF_A) ? BUF_B : BUF_A;
      first_d = 1'b0;
    end
    if (i_de) begin
      x_d = in_range ? (x_eff + X_W'(1)) : x_eff;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel_q     <= BUF_A;
      x_q       <= '0;
      first_q   <= 1'b1;
      de_prev_q <= 1'b0;
      vs_act_q  <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      x_q       <= x_d;
      first_q   <= first_d;
      de_prev_q <= i_de;
      vs_act_q  <= vs_act;
    end
  end

  lbuf_ram #(
    .WIDTH  (PIX_W),
    .DEPTH  (MAX_HACT),
    .ADDR_W (ADDR_W)
  ) u_ram_a (
    .clk     (clk),
    .we_i    (wr_en & (sel_eff == BUF_A)),
    .addr_i  (addr),
    .wdata_i (wr_pix),
    .rdata_o (rdata_a)
  );

  lbuf_ram #(
    .WIDTH  (PIX_W),
    .DEPTH  (MAX_HACT),
    .ADDR_W (ADDR_W)
  ) u_ram_b (
    .clk     (clk),
    .we_i    (wr_en & (sel_eff == BUF_B)),
    .addr_i  (addr),
    .wdata_i (wr_pix),
    .rdata_o (rdata_b)
  );

  // First pipeline stage: carry syncs and line context alongside the RAM read
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_p1_q     <= 1'b0;
      hs_p1_q     <= 1'b0;
      de_p1_q     <= 1'b0;
      valid_p1_q  <= 1'b0;
      first_p1_q  <= 1'b0;
      rd_sel_p1_q <= BUF_A;
      pix_p1_q    <= '0;
    end else begin
      vs_p1_q     <= i_vsync;
      hs_p1_q     <= i_hsync;
      de_p1_q     <= i_de;
      valid_p1_q  <= i_de & in_range;
      first_p1_q  <= first_eff;
      rd_sel_p1_q <= (sel_eff == BUF_A) ? BUF_B : BUF_A;
      pix_p1_q    <= wr_pix;
    end
  end

  // Output data select: blanking and out-of-range pixels are zero
  always_comb begin
    rd_pix = (rd_sel_p1_q == BUF_A) ? rdata_a : rdata_b;
    data_d = '0;
    if (de_p1_q && valid_p1_q) begin
      if (first_p1_q) begin
`ifdef LBUF_FIRST_LINE_ZERO_EN
        data_d = '0;
`else
        data_d = pix_p1_q;
`endif
      end else begin
        data_d = rd_pix;
      end
    end
  end

  // Second pipeline stage: registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_out_q <= 1'b0;
      hs_out_q <= 1'b0;
      de_out_q <= 1'b0;
      data_q   <= '0;
    end else begin
      vs_out_q <= vs_p1_q;
      hs_out_q <= hs_p1_q;
      de_out_q <= de_p1_q;
      data_q   <= data_d;
    end
  end

  assign o_vsync  = vs_out_q;
  assign o_hsync  = hs_out_q;
  assign o_de     = de_out_q;
  assign o_r_data = data_q[3*DATA_W-1:2*DATA_W];
  assign o_g_data = data_q[2*DATA_W-1:DATA_W];
  assign o_b_data = data_q[DATA_W-1:0];

endmodule

// File: tb/tb_line_buf_ctrl_top.sv
// Bench for line_buf_ctrl_top: two instances (MAX_HACT 2048 and 8) share the
// same video stream and are checked every cycle against a line-buffer model.
`timescale 1ns/1ps
module tb_line_buf_ctrl_top;

  localparam int DW = 10;
  localparam int PW = 3 * DW;
  localparam int VW = PW + 3;
  localparam int HSW = 1, HBP = 2, HACT = 10, HFP = 2;
  localparam int VSW = 1, VBP = 1, VACT = 4, VFP = 1;
  localparam int VTOT = VSW + VBP + VACT + VFP;

  typedef struct packed {
    logic          rst;
    logic          vs;
    logic          hs;
    logic          de;
    logic [PW-1:0] pix;
  } stim_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic vsync = 1'b0, hsync = 1'b0, de = 1'b0;
  logic [DW-1:0] rData = '0, gData = '0, bData = '0;

  logic o_vs0, o_hs0, o_de0, o_vs1, o_hs1, o_de1;
  logic [DW-1:0] o_r0, o_g0, o_b0, o_r1, o_g1, o_b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int mMax [2] = '{2048, 8};
  int mSel [2];
  int mX [2];
  bit mFirst [2];
  bit mPrevDe [2];
  bit mPrevVs [2];
  logic [PW-1:0] mBuf [2][2][2048];
  bit mValid [2][2][2048];
  logic [VW-1:0] pipeExp [2][2];
  logic [VW-1:0] pipeMask [2][2];
  logic [VW-1:0] expVec [2];
  logic [VW-1:0] obsVec [2];

  stim_t stimQ [$];

  line_buf_ctrl_top #(.DATA_W(DW), .MAX_HACT(2048), .VSYNC_POL(0)) dut (
    .clk(clk), .rstn(rstn), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
    .i_r_data(rData), .i_g_data(gData), .i_b_data(bData),
    .o_vsync(o_vs0), .o_hsync(o_hs0), .o_de(o_de0),
    .o_r_data(o_r0), .o_g_data(o_g0), .o_b_data(o_b0));

  line_buf_ctrl_top #(.DATA_W(DW), .MAX_HACT(8), .VSYNC_POL(0)) dut8 (
    .clk(clk), .rstn(rstn), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
    .i_r_data(rData), .i_g_data(gData), .i_b_data(bData),
    .o_vsync(o_vs1), .o_hsync(o_hs1), .o_de(o_de1),
    .o_r_data(o_r1), .o_g_data(o_g1), .o_b_data(o_b1));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle, update the line-buffer model, and sample both DUTs after the edge
  task automatic applyStimulus(input stim_t s);
    logic [VW-1:0] e [2];
    logic [VW-1:0] em [2];
    @(negedge clk);
    rstn = ~s.rst;
    vsync = s.vs;
    hsync = s.hs;
    de = s.de;
    {rData, gData, bData} = s.pix;
    for (int m = 0; m < 2; m++) begin
      e[m] = {s.vs, s.hs, s.de, {PW{1'b0}}};
      em[m] = '1;
      if (s.rst) begin
        mSel[m] = 0; mX[m] = 0; mFirst[m] = 1'b1; mPrevDe[m] = 1'b0; mPrevVs[m] = 1'b0;
      end else begin
        if (s.vs && !mPrevVs[m]) begin
          mSel[m] = 0; mX[m] = 0; mFirst[m] = 1'b1;
        end
        if (s.de) begin
          if (mX[m] < mMax[m]) begin
            if (mFirst[m]) begin
`ifdef LBUF_FIRST_LINE_ZERO_EN
              e[m][PW-1:0] = '0;
`else
              e[m][PW-1:0] = s.pix;
`endif
            end else if (mValid[m][1-mSel[m]][mX[m]]) begin
              e[m][PW-1:0] = mBuf[m][1-mSel[m]][mX[m]];
            end else begin
              em[m][PW-1:0] = '0;
            end
            mBuf[m][mSel[m]][mX[m]] = s.pix;
            mValid[m][mSel[m]][mX[m]] = 1'b1;
          end
          mX[m]++;
        end else begin
          if (mPrevDe[m]) begin
            mSel[m] = 1 - mSel[m];
            mFirst[m] = 1'b0;
          end
          mX[m] = 0;
        end
        mPrevDe[m] = s.de;
        mPrevVs[m] = s.vs;
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (s.rst) begin
        pipeExp[m][0] = '0; pipeExp[m][1] = '0;
        pipeMask[m][0] = '1; pipeMask[m][1] = '1;
      end else begin
        pipeExp[m][0] = pipeExp[m][1]; pipeMask[m][0] = pipeMask[m][1];
        pipeExp[m][1] = e[m]; pipeMask[m][1] = em[m];
      end
    end
    #1;
    obsVec[0] = {o_vs0, o_hs0, o_de0, o_r0, o_g0, o_b0} & pipeMask[0][0];
    obsVec[1] = {o_vs1, o_hs1, o_de1, o_r1, o_g1, o_b1} & pipeMask[1][0];
    expVec[0] = pipeExp[0][0] & pipeMask[0][0];
    expVec[1] = pipeExp[1][0] & pipeMask[1][0];
    cyc++;
  endtask

  // Append one frame of video timing; rstCol >= 0 asserts reset for two cycles on line rstLine
  task automatic appendFrame(input bit randPix, input bit randLen, input int rstLine, input int rstCol);
    stim_t s;
    int hact, htot, y, x;
    logic [DW-1:0] v;
    for (int ln = 0; ln < VTOT; ln++) begin
      hact = randLen ? int'($urandom_range(6, 12)) : HACT;
      htot = HSW + HBP + hact + HFP;
      for (int col = 0; col < htot; col++) begin
        y = ln - VSW - VBP;
        x = col - HSW - HBP;
        s.rst = (ln == rstLine) && (col == rstCol || col == rstCol + 1);
        s.vs = (ln < VSW);
        s.hs = (col < HSW);
        s.de = (y >= 0) && (y < VACT) && (x >= 0) && (x < hact);
        v = DW'(16 * y + x);
        s.pix = randPix ? PW'($urandom) : (s.de ? {v, v, v} : '0);
        stimQ.push_back(s);
      end
    end
  endtask

  // Reset holds outputs at zero, then the first o_de follows i_de by two cycles
  task automatic test_reset();
    stim_t s;
    int inDe, outDe;
    inDe = -1; outDe = -1;
    stimQ.delete();
    for (int i = 0; i < 2; i++) begin
      s.rst = 1'b1; s.vs = 1'b1; s.hs = 1'b1; s.de = 1'b1; s.pix = PW'($urandom);
      stimQ.push_back(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = '0;
      stimQ.push_back(s);
    end
    appendFrame(1'b0, 1'b0, -1, -1);
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(stimQ[i]);
      if (stimQ[i].rst) begin
        checks++;
        if (obsVec[0] !== '0 || obsVec[1] !== '0) begin
          errors++;
          $display("[TB] FAIL reset_zero cyc=%0d got %h/%h want 0", cyc, obsVec[0], obsVec[1]);
        end
      end
      if (inDe < 0 && stimQ[i].de && !stimQ[i].rst) inDe = i;
      // the sample after step i lies in the cycle following input cycle i
      if (outDe < 0 && obsVec[0][PW]) outDe = i + 1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obsVec[m] !== expVec[m]) begin
          errors++;
          $display("[TB] FAIL reset_frame dut%0d cyc=%0d got %h want %h", m, cyc, obsVec[m], expVec[m]);
        end
      end
    end
    checks++;
    if (inDe < 0 || outDe - inDe != 2) begin
      errors++;
      $display("[TB] FAIL de_latency got %0d want 2", outDe - inDe);
    end
  endtask

  // Ten standard frames of 16*y+x pixels; each line shows the previous one
  task automatic test_frames();
    stimQ.delete();
    for (int f = 0; f < 10; f++) appendFrame(1'b0, 1'b0, -1, -1);
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(stimQ[i]);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obsVec[m] !== expVec[m]) begin
          errors++;
          $display("[TB] FAIL frames dut%0d cyc=%0d got %h want %h", m, cyc, obsVec[m], expVec[m]);
        end
      end
    end
  endtask

  // Random pixel values and random line lengths, including lines past the short buffer
  task automatic test_random();
    stimQ.delete();
    for (int f = 0; f < 4; f++) appendFrame(1'b1, 1'b1, -1, -1);
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(stimQ[i]);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obsVec[m] !== expVec[m]) begin
          errors++;
          $display("[TB] FAIL random dut%0d cyc=%0d got %h want %h", m, cyc, obsVec[m], expVec[m]);
        end
      end
    end
  endtask

  // Reset pulsed in the middle of active line 2, followed by a clean frame
  task automatic test_mid_reset();
    stimQ.delete();
    appendFrame(1'b0, 1'b0, VSW + VBP + 2, HSW + HBP + 4);
    appendFrame(1'b0, 1'b0, -1, -1);
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(stimQ[i]);
      if (stimQ[i].rst) begin
        checks++;
        if (obsVec[0] !== '0) begin
          errors++;
          $display("[TB] FAIL mid_reset_zero cyc=%0d got %h want 0", cyc, obsVec[0]);
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obsVec[m] !== expVec[m]) begin
          errors++;
          $display("[TB] FAIL mid_reset dut%0d cyc=%0d got %h want %h", m, cyc, obsVec[m], expVec[m]);
        end
      end
    end
  endtask

  // Dense lines with one-cycle gaps; vsync asserts on the very first pixel of each frame
  task automatic test_back_to_back();
    stim_t s;
    int len;
    stimQ.delete();
    for (int f = 0; f < 3; f++) begin
      for (int ln = 0; ln < 5; ln++) begin
        len = $urandom_range(4, 12);
        for (int x = 0; x < len; x++) begin
          s.rst = 1'b0;
          s.vs = (ln == 0) && (x == 0);
          s.hs = 1'b0;
          s.de = 1'b1;
          s.pix = PW'($urandom);
          stimQ.push_back(s);
        end
        s = '0;
        s.hs = 1'b1;
        stimQ.push_back(s);
      end
    end
    for (int i = 0; i < 4; i++) begin
      s = '0;
      stimQ.push_back(s);
    end
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(stimQ[i]);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obsVec[m] !== expVec[m]) begin
          errors++;
          $display("[TB] FAIL back_to_back dut%0d cyc=%0d got %h want %h", m, cyc, obsVec[m], expVec[m]);
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      pipeExp[m][0] = '0; pipeExp[m][1] = '0;
      pipeMask[m][0] = '1; pipeMask[m][1] = '1;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 2048; a++) mValid[m][b][a] = 1'b0;
    end
    test_reset();
    test_frames();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl_top.md
LINE_BUF_CTRL_TOP -- requirements
Module: line_buf_ctrl_top

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning bits per colour channel.
REQ-002 SHALL have parameter MAX_HACT, default 2048, meaning maximum stored pixels per line (address width = clog2(MAX_HACT)).
REQ-003 SHALL have parameter VSYNC_POL, default 0, meaning vsync polarity (0 active high, 1 active low).
REQ-004 One clock; reset is synchronous and active-low: clk input 1 (rising-edge clock), then rstn input 1 (synchronous, active-low reset).
REQ-005 Input i_vsync, 1 bit: frame sync.
REQ-006 Input i_hsync, 1 bit: line sync.
REQ-007 Input i_de, 1 bit: active-pixel enable.
REQ-008 Inputs i_r_data, i_g_data, i_b_data, DATA_W bits each: pixel colour.
REQ-009 Outputs o_vsync, o_hsync, o_de, 1 bit each: delayed syncs.
REQ-010 Outputs o_r_data, o_g_data, o_b_data, DATA_W bits each: previous-line pixel colour.

Function
REQ-011 Fixed latency of 2 clk cycles: o_vsync/o_hsync/o_de at cycle t+2 SHALL equal i_vsync/i_hsync/i_de at cycle t, with no polarity change.
REQ-012 Two line buffers (A, B) of MAX_HACT x 3*DATA_W SHALL operate ping-pong: while the current line writes one buffer, the other is read.
REQ-013 Write: each cycle with i_de=1 SHALL write {r,g,b} at x = count of prior i_de=1 cycles in this line; x resets to 0 on the i_de falling edge.
REQ-014 Read: in the same cycle the opposite buffer SHALL be read at the same x; synchronous RAM read of 1 cycle, then one output register, giving o_*_data aligned with o_de.
REQ-015 The buffer select SHALL toggle on every i_de falling edge.
REQ-016 Frame start = vsync assertion edge (per VSYNC_POL); it SHALL reset select to A, reset x to 0, and set the first-line flag.
REQ-017 With the first-line flag set, o_*_data SHALL follow REQ-030/031; the flag clears on the first i_de falling edge of the frame.
REQ-018 When o_de=0, o_*_data SHALL be 0.
REQ-019 For x >= MAX_HACT, writes SHALL be discarded and output data SHALL be 0 (no address wrap).
REQ-020 If the current line is longer than the stored line, pixels beyond the stored length SHALL output whatever the buffer holds (stale data permitted, no error).
REQ-021 Vsync assertion coinciding with i_de=1 SHALL apply frame start first; that pixel is written to buffer A at x=0.

Reset
REQ-022 While rstn=0 at a clk edge, all outputs SHALL be 0, x=0, select=A, first-line flag=1, and the sync delay pipeline cleared.
REQ-023 Buffer RAM contents SHALL NOT be reset.
REQ-024 Reset mid-frame: after release, behaviour SHALL be as at frame start until the next vsync.

Configuration
REQ-030 Macro LBUF_FIRST_LINE_ZERO_EN defined: during the first active line of a frame, o_*_data SHALL be 0.
REQ-031 Macro undefined: during the first active line of a frame, o_*_data SHALL equal the current input pixel delayed 2 cycles (pass-through).

Structure
REQ-032 Package lbuf_pkg SHALL hold DATA_W and ADDR_W defaults plus a packed rgb_t typedef {r,g,b}.
REQ-033 Sub-module lbuf_ram (single-port, synchronous read, write-enable) SHALL be instantiated twice.
REQ-034 clk_gen SHALL remain a bench-only clock model and SHALL NOT be part of this block.

Verification
(Bench timing: HSW=1, HBP=2, HACT=10, HFP=2, VSW=1, VBP=1, VACT=4, VFP=1; pixel value = 16*y + x on all channels.)
REQ-040 Reset held for 20 ns -> all outputs 0; first o_de rises exactly 2 cycles after i_de.
REQ-041 Frame line y=1 -> o_*_data = 0..9 (line 0); line y=3 -> 32..41.
REQ-042 First line with LBUF_FIRST_LINE_ZERO_EN defined -> data all 0; undefined -> data 0..9.
REQ-043 Ten consecutive frames -> identical output per frame; select resets at each vsync with no cross-frame data leakage.
REQ-044 rstn pulsed low mid-line 2 -> outputs 0 during reset; next line treated as first line.
REQ-045 MAX_HACT=8 with HACT=10 -> pixels x=8,9 output 0 on the following line.
